// File: rtl/bus_burst_pkg.sv
// Shared types and sizing helpers for the burst engine, its register bank and its bus interface.
package bus_burst_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_WAIT,
        S_XFER,
        S_DONE
    } state_t;

    // The wait counter is 4 bits wide.
    localparam int MAX_WAIT = 15;

    function automatic int len_w(input int max_len);
        return (max_len > 1) ? $clog2(max_len) : 1;
    endfunction

    function automatic int depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/bus_burst_if.sv
// Request/response bundle between a requester (master) and the burst engine (slave).
interface bus_burst_if
    import bus_burst_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int LEN_W  = len_w(4)
);
    logic              req;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic              busy;
    logic              wnext;
    logic              data_valid;
    logic [DATA_W-1:0] rdata;
    logic              done;
    logic              err;
    logic              drop;

    modport master (
        output req, rw, addr, len, wdata,
        input  ack, busy, wnext, data_valid, rdata, done, err, drop
    );

    modport slave (
        input  req, rw, addr, len, wdata,
        output ack, busy, wnext, data_valid, rdata, done, err, drop
    );
endinterface

// File: rtl/bus_burst_regbank.sv
// DEPTH x DATA_W storage: synchronous write, combinational read, whole bank cleared by reset.
module bus_burst_regbank
    import bus_burst_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    localparam int DEPTH = depth(ADDR_W);

    logic [DEPTH-1:0][DATA_W-1:0] mem;

    always_ff @(posedge clk) begin
        if (!rst_n)
            mem <= '0;
        else if (ena && we)
            mem[addr] <= wdata;
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/bus_burst_engine.sv
// Burst read/write engine: edge-triggered requests, per-beat wait states, one pending slot,
// range-checked bursts against an internal register bank.
module bus_burst_engine
    import bus_burst_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int MAX_LEN     = 4,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    bus_burst_if.slave  bus
);
    localparam int          LEN_W = len_w(MAX_LEN);
    localparam int          DEPTH = depth(ADDR_W);
    localparam logic [3:0]  WS    = 4'((WAIT_STATES > MAX_WAIT) ? MAX_WAIT : WAIT_STATES);

    state_t            state, state_nxt;
    logic              req_q, drop_q, err_q;
    logic              act_rw;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  act_len, beat;
    logic [3:0]        wcnt;
    logic              pend_vld, pend_rw;
    logic [ADDR_W-1:0] pend_addr;
    logic [LEN_W-1:0]  pend_len;
    logic              take_req, take_pend;
    logic              req_edge, busy_edge, cap_pend, drop_nxt;
    logic              range_err, last_beat, mem_we;
    logic [DATA_W-1:0] mem_rdata;

    assign req_edge  = bus.req && !req_q;
    // An edge that cannot start immediately competes for the single pending slot.
    assign busy_edge = req_edge && (state != S_IDLE || pend_vld);
    assign cap_pend  = busy_edge && !pend_vld;
    assign drop_nxt  = busy_edge && pend_vld;
    // One extra bit so addr + len cannot wrap past the top of the bank.
    assign range_err = ({1'b0, cur_addr} + (ADDR_W+1)'(act_len)) > (ADDR_W+1)'(DEPTH - 1);
    assign last_beat = (beat == act_len);
    assign mem_we    = (state == S_XFER) && !act_rw;

    always_comb begin
        state_nxt = state;
        take_req  = 1'b0;
        take_pend = 1'b0;
        case (state)
            S_IDLE: begin
                if (pend_vld) begin
                    take_pend = 1'b1;
                    state_nxt = S_ACK;
                end else if (req_edge) begin
                    take_req  = 1'b1;
                    state_nxt = S_ACK;
                end
            end
            S_ACK:  state_nxt = range_err ? S_DONE : (WS == 4'd0) ? S_XFER : S_WAIT;
            S_WAIT: if (wcnt <= 4'd1) state_nxt = S_XFER;
            S_XFER: state_nxt = last_beat ? S_DONE : (WS == 4'd0) ? S_XFER : S_WAIT;
            S_DONE: begin
                if (pend_vld) begin
                    take_pend = 1'b1;
                    state_nxt = S_ACK;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            req_q     <= 1'b0;
            drop_q    <= 1'b0;
            err_q     <= 1'b0;
            act_rw    <= 1'b0;
            cur_addr  <= '0;
            act_len   <= '0;
            beat      <= '0;
            wcnt      <= '0;
            pend_vld  <= 1'b0;
            pend_rw   <= 1'b0;
            pend_addr <= '0;
            pend_len  <= '0;
        end else if (ena) begin
            state  <= state_nxt;
            req_q  <= bus.req;
            drop_q <= drop_nxt;
            if (take_req) begin
                act_rw   <= bus.rw;
                cur_addr <= bus.addr;
                act_len  <= bus.len;
                beat     <= '0;
            end else if (take_pend) begin
                act_rw   <= pend_rw;
                cur_addr <= pend_addr;
                act_len  <= pend_len;
                beat     <= '0;
            end else if (state == S_XFER && !last_beat) begin
                cur_addr <= cur_addr + 1'b1;
                beat     <= beat + 1'b1;
            end
            if (state == S_ACK)
                err_q <= range_err;
            if (state == S_ACK || (state == S_XFER && !last_beat))
                wcnt <= WS;
            else if (state == S_WAIT)
                wcnt <= wcnt - 1'b1;
            if (cap_pend) begin
                pend_vld  <= 1'b1;
                pend_rw   <= bus.rw;
                pend_addr <= bus.addr;
                pend_len  <= bus.len;
            end else if (take_pend) begin
                pend_vld  <= 1'b0;
            end
        end
    end

    bus_burst_regbank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .we    (mem_we),
        .addr  (cur_addr),
        .wdata (bus.wdata),
        .rdata (mem_rdata)
    );

    assign bus.ack        = (state == S_ACK);
    assign bus.busy       = (state != S_IDLE);
    assign bus.wnext      = mem_we;
    assign bus.data_valid = (state == S_XFER) && act_rw;
    assign bus.rdata      = bus.data_valid ? mem_rdata : '0;
    assign bus.done       = (state == S_DONE);
    assign bus.err        = bus.done && err_q;
    assign bus.drop       = drop_q;
endmodule

// File: tb/tb_bus_burst_engine.sv
// Scoreboard bench for bus_burst_engine: stimulus pushes expected output events, a negedge
// monitor pops and compares them, along with busy run lengths and whole-output snapshots.
module tb_bus_burst_engine;

    typedef struct {
        int         cyc;
        logic [5:0] fl;   // {ack, wnext, data_valid, done, err, drop}
        logic [7:0] rd;
    } ev_t;

    typedef struct {
        int          cyc;
        logic [14:0] v;   // {busy, flags, rdata}
    } st_t;

    logic clk = 1'b0;
    logic rst_n;
    logic ena;

    always #5 clk = ~clk;

    bus_burst_if #(.DATA_W(8), .ADDR_W(4), .LEN_W(2)) bus ();

    bus_burst_engine #(
        .DATA_W(8), .ADDR_W(4), .MAX_LEN(4), .WAIT_STATES(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    ev_t        exp_q[$];
    st_t        st_q[$];
    int         bexp_q[$];
    logic [7:0] wq[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    int         run = 0;
    bit         stim_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write-data feeder: present the next queued word while wnext is high.
    always @(negedge clk) begin
        if (bus.wnext)
            bus.wdata = (wq.size() != 0) ? wq.pop_front() : 8'h00;
    end

    always @(negedge clk) begin
        logic [5:0]  f;
        logic [14:0] v;
        ev_t         e;
        st_t         s;
        int          b;
        f = {bus.ack, bus.wnext, bus.data_valid, bus.done, bus.err, bus.drop};
        v = {bus.busy, f, bus.rdata};
        while (st_q.size() != 0 && st_q[0].cyc <= cyc) begin
            s = st_q.pop_front();
            n_cmp++;
            if (v !== s.v) begin
                n_err++;
                $display("FAIL outputs@%0d: got %h expected %h", cyc, v, s.v);
            end
        end
        if (f != 6'b0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL event@%0d: got flags=%b rdata=%h, expected no event", cyc, f, bus.rdata);
            end else begin
                e = exp_q.pop_front();
                if (e.fl !== f || e.rd !== bus.rdata || e.cyc != cyc) begin
                    n_err++;
                    $display("FAIL event: got flags=%b rdata=%h cyc=%0d expected flags=%b rdata=%h cyc=%0d",
                             f, bus.rdata, cyc, e.fl, e.rd, e.cyc);
                end
            end
        end
        if (bus.busy) begin
            run++;
        end else if (run != 0) begin
            n_cmp++;
            if (bexp_q.size() == 0) begin
                n_err++;
                $display("FAIL busy_run: got %0d cycles, expected no busy period", run);
            end else begin
                b = bexp_q.pop_front();
                if (b != run) begin
                    n_err++;
                    $display("FAIL busy_run: got %0d cycles expected %0d", run, b);
                end
            end
            run = 0;
        end
        if (stim_done) begin
            n_cmp++;
            if (exp_q.size() != 0 || st_q.size() != 0 || bexp_q.size() != 0) begin
                n_err++;
                $display("FAIL leftovers: got %0d events/%0d snapshots/%0d busy runs pending, expected 0",
                         exp_q.size(), st_q.size(), bexp_q.size());
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
            $finish;
        end
    end

    task automatic push_ev(input int c, input logic [5:0] f, input logic [7:0] d);
        ev_t e;
        e.cyc = c;
        e.fl  = f;
        e.rd  = d;
        exp_q.push_back(e);
    endtask

    task automatic push_st(input int c, input logic [14:0] v);
        st_t s;
        s.cyc = c;
        s.v   = v;
        st_q.push_back(s);
    endtask

    task automatic fire(input bit rw, input logic [3:0] a, input logic [1:0] l);
        bus.rw   = rw;
        bus.addr = a;
        bus.len  = l;
        bus.req  = 1'b1;
        @(negedge clk);
        bus.req  = 1'b0;
    endtask

    // Full transaction with hand-computed timing; shift delays everything after ACK.
    task automatic txn(input bit rw, input logic [3:0] a, input logic [1:0] l,
                       input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] d3,
                       input bit er, input int shift, input int busy_len, output int t0);
        logic [7:0] d [4];
        d  = '{d0, d1, d2, d3};
        t0 = cyc;
        push_ev(t0 + 1, 6'b100000, 8'h00);
        if (er) begin
            push_ev(t0 + 2, 6'b000110, 8'h00);
        end else begin
            for (int i = 0; i <= int'(l); i++) begin
                push_ev(t0 + 4 + 3*i + shift, rw ? 6'b001000 : 6'b010000, rw ? d[i] : 8'h00);
                if (!rw) wq.push_back(d[i]);
            end
            push_ev(t0 + 5 + 3*int'(l) + shift, 6'b000100, 8'h00);
        end
        bexp_q.push_back(busy_len);
        fire(rw, a, l);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || bus.busy) && n < 400);
        if (n >= 400) begin
            $display("FAIL timeout: got busy=%b with %0d events pending, expected idle within 400 cycles",
                     bus.busy, exp_q.size());
            $fatal(1, "bench stopped");
        end
        @(negedge clk);
    endtask

    initial begin
        int t;
        rst_n    = 1'b0;
        ena      = 1'b1;
        bus.req  = 1'b0;
        bus.rw   = 1'b0;
        bus.addr = '0;
        bus.len  = '0;
        push_st(2, 15'h0000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // single write then read back
        txn(1'b0, 4'd3, 2'd0, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b0, 0, 5, t);
        wait_idle();
        txn(1'b1, 4'd3, 2'd0, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b0, 0, 5, t);
        wait_idle();

        // four-beat burst write, burst read back
        txn(1'b0, 4'd4, 2'd3, 8'h10, 8'h20, 8'h30, 8'h40, 1'b0, 0, 14, t);
        wait_idle();
        txn(1'b1, 4'd4, 2'd3, 8'h10, 8'h20, 8'h30, 8'h40, 1'b0, 0, 14, t);
        wait_idle();

        // out of range: 14 + 3 > 15, then confirm addr 14 untouched
        txn(1'b0, 4'd14, 2'd3, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 1'b1, 0, 2, t);
        wait_idle();
        txn(1'b1, 4'd14, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 0, 5, t);
        wait_idle();

        // back-to-back: B queued in A's WAIT, C dropped during A's XFER
        t = cyc;
        push_ev(t + 1,  6'b100000, 8'h00);
        push_ev(t + 4,  6'b010000, 8'h00);
        wq.push_back(8'h11);
        push_ev(t + 5,  6'b000101, 8'h00);
        push_ev(t + 6,  6'b100000, 8'h00);
        push_ev(t + 9,  6'b001000, 8'h11);
        push_ev(t + 10, 6'b000100, 8'h00);
        bexp_q.push_back(10);
        fire(1'b0, 4'd0, 2'd0);
        @(negedge clk);
        fire(1'b1, 4'd0, 2'd0);
        @(negedge clk);
        fire(1'b1, 4'd5, 2'd0);
        wait_idle();

        // reset during beat 2 of a burst write
        t = cyc;
        push_ev(t + 1, 6'b100000, 8'h00);
        push_ev(t + 4, 6'b010000, 8'h00);
        push_ev(t + 7, 6'b010000, 8'h00);
        wq.push_back(8'h55);
        wq.push_back(8'h66);
        bexp_q.push_back(7);
        push_st(t + 8, 15'h0000);
        fire(1'b0, 4'd4, 2'd3);
        while (cyc < t + 7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle();
        txn(1'b1, 4'd4, 2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 0, 14, t);
        wait_idle();
        txn(1'b1, 4'd3, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 0, 5, t);
        wait_idle();

        // ena low for 5 cycles in WAIT: everything after shifts by 5
        for (int k = 2; k <= 7; k++) push_st(cyc + k, {1'b1, 14'h0000});
        txn(1'b0, 4'd8, 2'd1, 8'h21, 8'h22, 8'h00, 8'h00, 1'b0, 5, 13, t);
        @(negedge clk);
        ena = 1'b0;
        repeat (5) @(negedge clk);
        ena = 1'b1;
        wait_idle();
        txn(1'b1, 4'd8, 2'd1, 8'h21, 8'h22, 8'h00, 8'h00, 1'b0, 0, 8, t);
        wait_idle();

        stim_done = 1'b1;
    end

endmodule

// File: doc/bus_burst_engine.md
# bus_burst_engine

Parametrised successor to the single-beat bus transaction FSM. It accepts edge-triggered requests with an address and burst length, then runs read or write bursts against an internal register bank. Each beat takes a programmable number of wait states, and the engine holds one pending request so back-to-back requests are not lost. The block sits behind the TinyTapeout top wrapper, which maps its ports onto `ui_in`, `uio_*` and `uo_out`.

## Interface

Parameters:
- `DATA_W`, 8: data word width.
- `ADDR_W`, 4: address width; bank depth is `DEPTH = 2**ADDR_W`.
- `MAX_LEN`, 4: maximum beats per burst; power of two, ≥2. `LEN_W = $clog2(MAX_LEN)`.
- `WAIT_STATES`, 2: wait cycles before each beat, range 0..15.

Ports:
- `clk`  in  1: the only clock.
- `rst_n`  in  1: reset, synchronous and active-low.
- `ena`  in  1: clock enable; when 0, all state freezes.
- `req`  in  1: request; a rising edge (`req & ~req_q`) is one request.
- `rw`  in  1: 0 = write, 1 = read; sampled with the request edge.
- `addr`  in  ADDR_W: start address; sampled with the request edge.
- `len`  in  LEN_W: beats minus one; sampled with the request edge.
- `wdata`  in  DATA_W: write data; consumed in the cycle `wnext` = 1.
- `ack`  out  1: one-cycle pulse, request accepted.
- `busy`  out  1: high whenever state ≠ IDLE.
- `wnext`  out  1: write beat; `wdata` is stored this cycle.
- `data_valid`  out  1: read beat; `rdata` is valid this cycle.
- `rdata`  out  DATA_W: read data; 0 when `data_valid` = 0.
- `done`  out  1: one-cycle pulse at the end of a transaction.
- `err`  out  1: asserted only together with `done`; marks an out-of-range burst.
- `drop`  out  1: one-cycle pulse; a request edge was discarded because the pending slot was full.

## Operation

- States: IDLE, ACK, WAIT, XFER, DONE. All outputs are decoded from registered state.
- IDLE, request edge: latch rw/addr/len into the active slot, then go to ACK.
- ACK asserts `ack`. Range check uses ADDR_W+1-bit arithmetic: if `addr + len > DEPTH-1`, go to DONE with error flagged and touch no memory.
  - Otherwise, load the wait counter with WAIT_STATES and go to WAIT.
  - If WAIT_STATES = 0, go directly to XFER.
- WAIT: decrement the counter; go to XFER when it reaches 0.
- XFER performs one beat at `cur_addr`:
  - Write: `mem[cur_addr] <= wdata` and assert `wnext`.
  - Read: `rdata = mem[cur_addr]` and assert `data_valid`.
  - Last beat (beat count = len): go to DONE.
  - Otherwise: increment `cur_addr` and the beat count, then go to WAIT (or XFER if WAIT_STATES = 0).
- DONE asserts `done`, plus `err` if flagged. If the pending slot is full, move it to the active slot and go to ACK; otherwise go to IDLE.
- Request edge while busy:
  - Pending slot empty: capture rw/addr/len. A capture coinciding with DONE is honoured next cycle.
  - Pending slot full: discard the request and pulse `drop`.
- `ena` = 0: state, counters, `req_q`, pending slot and memory all hold. Outputs hold their decoded values. Request edges during this time are lost.
- Reset (`rst_n` = 0 at a clock edge, in any state, including mid-burst):
  - Go to IDLE and clear the pending slot, `req_q` and every memory word to 0.
  - All outputs read 0 in the following cycle.

## Timing

- The request edge is sampled at edge E0. ACK is cycle 1. Each beat takes WAIT_STATES wait cycles plus 1 XFER cycle. DONE is the last cycle.
- Busy duration is `2 + (len+1)*(WAIT_STATES+1)` cycles; with the defaults, a single beat is busy for 5 cycles.
- Error path: busy for 2 cycles (ACK, DONE).
- Consecutive beats are `WAIT_STATES+1` cycles apart.
- A pending request goes from DONE straight to ACK. `busy` stays high with no gap.
- `rdata` is combinational from the bank and the registered address, with no extra latency.

## Structure

- Package `bus_burst_pkg`: state enum, `LEN_W`/`DEPTH` helper functions, maximum WAIT_STATES constant.
- Sub-module `bus_burst_regbank`: DEPTH×DATA_W storage with synchronous write, combinational read and synchronous clear on reset.
- The FSM, wait counter, beat counter and pending slot live in `bus_burst_engine`.

## Test plan

All scenarios use default parameters.
- Single write, addr=3, len=0, wdata=0xA5: `ack` at cycle 1, `wnext` at cycle 4, `done` at cycle 5, `busy` high for 5 cycles. A later read of addr 3 gives `data_valid` with `rdata`=0xA5.
- Burst write, addr=4, len=3, with wdata stepping 0x10/0x20/0x30/0x40 on each `wnext`: `wnext` pulses 3 cycles apart, `busy` high for 14 cycles. A burst read of addr 4, len 3 returns the same four values in order.
- Out of range, addr=14, len=3: `ack`, then `done`+`err` on the next cycle, no `wnext`. A read of addr 14 returns 0x00.
- Back-to-back: a second edge during the first request's WAIT gives DONE→ACK with `busy` continuously high. A third edge before that DONE pulses `drop` and is never executed.
- Reset mid-burst: `rst_n` low during beat 2 of a write. The next cycle shows all outputs 0 and state IDLE, and addresses 4..7 read 0x00.
- `ena` low for 5 cycles during WAIT: every later event shifts by exactly 5 cycles, and no output changes while `ena` is low.
